// File: rtl/if_stage_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: owns the PC, runs the
// instruction-memory read handshake, buffers words across stalls and squashes wrong-path fetches.
module if_stage_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_READ,
   input  logic [31:0] IMEM_READDATA,
   input  logic        IMEM_BUSYWAIT,
   output logic        IF_BUSY,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_PC4,
   output logic [31:0] IFID_INSTR,
   output logic        IFID_VALID,
   output logic [6:0]  OP,
   output logic [4:0]  RD,
   output logic [2:0]  FUN3,
   output logic [4:0]  RS1,
   output logic [4:0]  RS2,
   output logic [6:0]  FUN7
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrop} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        complete;
   logic [31:0] target_aligned;

   assign target_aligned = BRANCH_TARGET & ~32'd3;

   always_comb begin
      IMEM_READ = 1'b0;
      IMEM_ADDR = pc_q;
      IF_BUSY   = 1'b0;
      unique case (state_q)
         StFetch: begin
            IMEM_READ = 1'b1;
            IF_BUSY   = IMEM_BUSYWAIT;
         end
         StDrop: begin
            // Keep the address of the abandoned read stable until memory lets go of it.
            IMEM_READ = 1'b1;
            IMEM_ADDR = drop_addr_q;
            IF_BUSY   = 1'b1;
         end
         default: ;
      endcase
   end

   assign complete = IMEM_READ & ~IMEM_BUSYWAIT;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drop_addr_d  = drop_addr_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;

      if (state_q == StIdle) begin
         state_d = StFetch;
      end else if (BRANCH_TAKEN) begin
         pc_d         = target_aligned;
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
         hold_pc_d    = 32'd0;
         hold_instr_d = 32'd0;
         if (IMEM_READ && IMEM_BUSYWAIT) begin
            state_d = StDrop;
            if (state_q == StFetch) begin
               drop_addr_d = pc_q;
            end
         end else begin
            state_d = StFetch;
         end
      end else begin
         unique case (state_q)
            StFetch: begin
               if (complete && !STALL) begin
                  ifid_pc_d    = pc_q;
                  ifid_pc4_d   = pc_q + 32'd4;
                  ifid_instr_d = IMEM_READDATA;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_q + 32'd4;
               end else if (complete) begin
                  hold_pc_d    = pc_q;
                  hold_instr_d = IMEM_READDATA;
                  pc_d         = pc_q + 32'd4;
                  state_d      = StHold;
               end else if (!STALL) begin
                  ifid_instr_d = NOP_INSTR;
                  ifid_valid_d = 1'b0;
               end
            end
            StHold: begin
               if (!STALL) begin
                  ifid_pc_d    = hold_pc_q;
                  ifid_pc4_d   = hold_pc_q + 32'd4;
                  ifid_instr_d = hold_instr_q;
                  ifid_valid_d = 1'b1;
                  hold_pc_d    = 32'd0;
                  hold_instr_d = 32'd0;
                  state_d      = StFetch;
               end
            end
            StDrop: begin
               if (!STALL) begin
                  ifid_instr_d = NOP_INSTR;
                  ifid_valid_d = 1'b0;
               end
               if (complete) begin
                  state_d = StFetch;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         drop_addr_q  <= 32'd0;
         hold_pc_q    <= 32'd0;
         hold_instr_q <= 32'd0;
         ifid_pc_q    <= 32'd0;
         ifid_pc4_q   <= 32'd4;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign IFID_PC    = ifid_pc_q;
   assign IFID_PC4   = ifid_pc4_q;
   assign IFID_INSTR = ifid_instr_q;
   assign IFID_VALID = ifid_valid_q;

   assign OP   = ifid_instr_q[6:0];
   assign RD   = ifid_instr_q[11:7];
   assign FUN3 = ifid_instr_q[14:12];
   assign RS1  = ifid_instr_q[19:15];
   assign RS2  = ifid_instr_q[24:20];
   assign FUN7 = ifid_instr_q[31:25];

endmodule

// File: tb/tb_if_stage_unit.sv
// Bench for if_stage_unit: directed scenarios with literal expectations, then random stimulus,
// all cycles compared against a transaction-level fetch model.
module tb_if_stage_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        STALL = 1'b0;
   logic        BRANCH_TAKEN = 1'b0;
   logic [31:0] BRANCH_TARGET = 32'd0;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_READ;
   logic [31:0] IMEM_READDATA;
   logic        IMEM_BUSYWAIT = 1'b0;
   logic        IF_BUSY;
   logic [31:0] IFID_PC, IFID_PC4, IFID_INSTR;
   logic        IFID_VALID;
   logic [6:0]  OP, FUN7;
   logic [4:0]  RD, RS1, RS2;
   logic [2:0]  FUN3;

   int n_checks = 0;
   int n_pass   = 0;

   if_stage_unit dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .STALL         (STALL),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .BRANCH_TARGET (BRANCH_TARGET),
      .IMEM_ADDR     (IMEM_ADDR),
      .IMEM_READ     (IMEM_READ),
      .IMEM_READDATA (IMEM_READDATA),
      .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
      .IF_BUSY       (IF_BUSY),
      .IFID_PC       (IFID_PC),
      .IFID_PC4      (IFID_PC4),
      .IFID_INSTR    (IFID_INSTR),
      .IFID_VALID    (IFID_VALID),
      .OP            (OP),
      .RD            (RD),
      .FUN3          (FUN3),
      .RS1           (RS1),
      .RS2           (RS2),
      .FUN7          (FUN7)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h02A38533;
      return a ^ 32'h5EED0001;
   endfunction

   assign IMEM_READDATA = mem_word(IMEM_ADDR);

   // Model: fetch position, optional held word, optional abandoned read, IF/ID contents.
   bit          m_known = 0;
   bit          m_started;
   logic [31:0] m_pc;
   bit          m_hold_v;
   logic [31:0] m_hold_pc, m_hold_instr;
   bit          m_drop;
   logic [31:0] m_drop_addr;
   logic [31:0] m_ifid_pc, m_ifid_instr;
   bit          m_ifid_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_compare();
      bit m_read;
      if (!m_known) return;
      m_read = m_started && !m_hold_v;
      chk("imem_read", {31'd0, IMEM_READ}, {31'd0, m_read});
      if (m_read) chk("imem_addr", IMEM_ADDR, m_drop ? m_drop_addr : m_pc);
      chk("if_busy", {31'd0, IF_BUSY}, {31'd0, m_read && (m_drop || IMEM_BUSYWAIT)});
      chk("ifid_pc", IFID_PC, m_ifid_pc);
      chk("ifid_pc4", IFID_PC4, m_ifid_pc + 32'd4);
      chk("ifid_instr", IFID_INSTR, m_ifid_instr);
      chk("ifid_valid", {31'd0, IFID_VALID}, {31'd0, m_ifid_valid});
      chk("fields", {OP, RD, FUN3, RS1, RS2, FUN7},
          {m_ifid_instr[6:0], m_ifid_instr[11:7], m_ifid_instr[14:12],
           m_ifid_instr[19:15], m_ifid_instr[24:20], m_ifid_instr[31:25]});
   endtask

   task automatic model_step(input logic rst, stall, br, input logic [31:0] tgt, input logic bw);
      bit read, done;
      if (!rst) begin
         m_known = 1; m_started = 0; m_pc = 32'd0; m_hold_v = 0; m_drop = 0;
         m_drop_addr = 32'd0; m_ifid_pc = 32'd0; m_ifid_instr = 32'h13; m_ifid_valid = 0;
         return;
      end
      if (!m_known) return;
      if (!m_started) begin
         m_started = 1;
         return;
      end
      read = !m_hold_v;
      done = read && !bw;
      if (br) begin
         if (read && bw) begin
            if (!m_drop) m_drop_addr = m_pc;
            m_drop = 1;
         end else begin
            m_drop = 0;
         end
         m_pc = {tgt[31:2], 2'b00};
         m_hold_v = 0;
         m_ifid_instr = 32'h13; m_ifid_valid = 0;
      end else if (m_hold_v) begin
         if (!stall) begin
            m_ifid_pc = m_hold_pc; m_ifid_instr = m_hold_instr; m_ifid_valid = 1;
            m_hold_v = 0;
         end
      end else if (m_drop) begin
         if (!stall) begin
            m_ifid_instr = 32'h13; m_ifid_valid = 0;
         end
         if (done) m_drop = 0;
      end else if (done) begin
         if (!stall) begin
            m_ifid_pc = m_pc; m_ifid_instr = mem_word(m_pc); m_ifid_valid = 1;
         end else begin
            m_hold_pc = m_pc; m_hold_instr = mem_word(m_pc); m_hold_v = 1;
         end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_ifid_instr = 32'h13; m_ifid_valid = 0;
      end
   endtask

   // Apply inputs just after a negedge, compare, cross the posedge, return at next negedge.
   task automatic step(input logic rst, stall, br, input logic [31:0] tgt, input logic bw);
      RESET = rst; STALL = stall; BRANCH_TAKEN = br; BRANCH_TARGET = tgt; IMEM_BUSYWAIT = bw;
      #1;
      model_compare();
      @(posedge CLK);
      model_step(rst, stall, br, tgt, bw);
      @(negedge CLK);
   endtask

   initial begin
      @(negedge CLK);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rst_instr", IFID_INSTR, 32'h13);
      chk("rst_valid", {31'd0, IFID_VALID}, 32'd0);
      chk("rst_pc4", IFID_PC4, 32'd4);
      chk("rst_read", {31'd0, IMEM_READ}, 32'd0);

      step(1, 0, 0, 0, 0);
      chk("first_read", {31'd0, IMEM_READ}, 32'd1);
      chk("first_addr", IMEM_ADDR, 32'd0);
      step(1, 0, 0, 0, 0);
      chk("pc0", IFID_PC, 32'd0);
      chk("valid0", {31'd0, IFID_VALID}, 32'd1);
      chk("op", {25'd0, OP}, 32'h33);
      chk("fun3", {29'd0, FUN3}, 32'd0);
      chk("fun7", {25'd0, FUN7}, 32'd1);
      chk("addr4", IMEM_ADDR, 32'd4);
      step(1, 0, 0, 0, 0);
      chk("pc4", IFID_PC, 32'd4);
      chk("addr8", IMEM_ADDR, 32'd8);

      for (int i = 0; i < 3; i++) begin
         RESET = 1; IMEM_BUSYWAIT = 1; #1;
         chk("busy_wait", {31'd0, IF_BUSY}, 32'd1);
         step(1, 0, 0, 0, 1);
         chk("busy_bubble", IFID_INSTR, 32'h13);
      end
      step(1, 0, 0, 0, 0);
      chk("pc8", IFID_PC, 32'd8);
      chk("addr12", IMEM_ADDR, 32'd12);

      step(1, 1, 0, 0, 0);
      chk("hold_keep", IFID_PC, 32'd8);
      chk("hold_read", {31'd0, IMEM_READ}, 32'd0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("hold_release", IFID_PC, 32'd12);
      chk("addr16", IMEM_ADDR, 32'd16);

      step(1, 0, 1, 32'h103, 1);
      chk("drop_addr", IMEM_ADDR, 32'd16);
      step(1, 0, 0, 0, 1);
      chk("drop_addr2", IMEM_ADDR, 32'd16);
      step(1, 0, 0, 0, 0);
      chk("redirect", IMEM_ADDR, 32'h100);
      chk("drop_valid", {31'd0, IFID_VALID}, 32'd0);
      step(1, 0, 0, 0, 0);
      chk("pc100", IFID_PC, 32'h100);

      step(1, 1, 1, 32'h40, 0);
      chk("sb_instr", IFID_INSTR, 32'h13);
      chk("sb_addr", IMEM_ADDR, 32'h40);

      step(1, 0, 1, 32'h200, 1);
      step(0, 0, 0, 0, 1);
      chk("rst_drop_read", {31'd0, IMEM_READ}, 32'd0);
      step(1, 0, 0, 0, 0);
      chk("rst_drop_pc", IMEM_ADDR, 32'd0);

      step(1, 0, 1, 32'hFFFFFFFC, 0);
      chk("wrap_addr", IMEM_ADDR, 32'hFFFFFFFC);
      step(1, 0, 0, 0, 0);
      chk("wrap_pc", IFID_PC, 32'hFFFFFFFC);
      chk("wrap_pc4", IFID_PC4, 32'd0);
      chk("wrap_next", IMEM_ADDR, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 2) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
